// File: rtl/mem_wb_stage.sv
// MEM and WB stages: data memory, branch redirect, MEM/WB register and writeback mux.
// Optional feature macro DMEM_SUBWORD_EN enables byte/halfword loads and stores selected by funct3.
// DMEM has no reset path and relies on the device's zeroed configuration-time RAM contents.
module mem_wb_stage #(
    parameter int DMEM_WORDS = 256,
    parameter int DMEM_AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_regwrite_e,
    input  logic [1:0]  ex_mem_result_src_e,
    input  logic        ex_mem_memwrite_e,
    input  logic        ex_mem_jump_e,
    input  logic        ex_mem_branch_e,
    input  logic        ex_mem_zero_flag_e,
    input  logic [31:0] ex_mem_pc_target_e,
    input  logic [31:0] ex_mem_alu_result_e,
    input  logic [31:0] ex_mem_writedata_e,
    input  logic [31:0] ex_mem_pc_plus_4_e,
    input  logic [4:0]  ex_mem_rd,
    input  logic [2:0]  ex_mem_funct3_e,
    output logic        pc_src,
    output logic [31:0] pc_branch_dest,
    output logic        writeback_control,
    output logic [4:0]  writeback_rd,
    output logic [31:0] writeback_data
);

    logic [DMEM_AW-1:0] word_idx;
    logic [3:0]         byte_we;
    logic [31:0]        store_data;
    logic [31:0]        mem_word;
    logic [31:0]        load_data;

    logic        regwrite_reg;
    logic [1:0]  result_src_reg;
    logic [31:0] alu_result_reg;
    logic [31:0] load_data_reg;
    logic [31:0] pc_plus_4_reg;
    logic [4:0]  rd_reg;

    assign pc_src         = ex_mem_jump_e | (ex_mem_branch_e & ex_mem_zero_flag_e);
    assign pc_branch_dest = ex_mem_pc_target_e;

    // Upper address bits are dropped, so accesses wrap modulo the memory size.
    assign word_idx = ex_mem_alu_result_e[DMEM_AW+1:2];

`ifdef DMEM_SUBWORD_EN
    logic [1:0]  byte_off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign byte_off = ex_mem_alu_result_e[1:0];

    always_comb begin
        byte_we    = 4'b1111;
        store_data = ex_mem_writedata_e;
        case (ex_mem_funct3_e)
            3'b000: begin
                byte_we    = 4'b0001 << byte_off;
                store_data = {4{ex_mem_writedata_e[7:0]}};
            end
            3'b001: begin
                byte_we    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{ex_mem_writedata_e[15:0]}};
            end
            default: byte_we = 4'b1111;
        endcase
        if (!ex_mem_memwrite_e || reset) begin
            byte_we = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = mem_word[{byte_off, 3'b000} +: 8];
        ld_half = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
        case (ex_mem_funct3_e)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h000000, ld_byte};
            3'b101:  load_data = {16'h0000, ld_half};
            default: load_data = mem_word;
        endcase
    end
`else
    logic unused_funct3;

    assign unused_funct3 = ^ex_mem_funct3_e;
    assign byte_we       = {4{ex_mem_memwrite_e & ~reset}};
    assign store_data    = ex_mem_writedata_e;
    assign load_data     = mem_word;
`endif

    // One memory per byte lane so partial stores need no read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DMEM_WORDS];

            always_ff @(posedge clk) begin
                if (byte_we[gi]) begin
                    lane_mem[word_idx] <= store_data[gi*8 +: 8];
                end
            end

            assign mem_word[gi*8 +: 8] = lane_mem[word_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_reg   <= 1'b0;
            result_src_reg <= 2'b00;
            alu_result_reg <= '0;
            load_data_reg  <= '0;
            pc_plus_4_reg  <= '0;
            rd_reg         <= '0;
        end else begin
            regwrite_reg   <= ex_mem_regwrite_e;
            result_src_reg <= ex_mem_result_src_e;
            alu_result_reg <= ex_mem_alu_result_e;
            load_data_reg  <= load_data;
            pc_plus_4_reg  <= ex_mem_pc_plus_4_e;
            rd_reg         <= ex_mem_rd;
        end
    end

    always_comb begin
        writeback_data = alu_result_reg;
        case (result_src_reg)
            2'b01:   writeback_data = load_data_reg;
            2'b10:   writeback_data = pc_plus_4_reg;
            default: writeback_data = alu_result_reg;
        endcase
    end

    // x0 is hardwired to zero, so a write to it is never forwarded to the register file.
    assign writeback_control = regwrite_reg & (rd_reg != 5'd0);
    assign writeback_rd      = rd_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected writeback pushed to a scoreboard queue at drive time.
// Subword cases run only when DMEM_SUBWORD_EN is defined.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        ex_mem_regwrite_e;
    logic [1:0]  ex_mem_result_src_e;
    logic        ex_mem_memwrite_e;
    logic        ex_mem_jump_e;
    logic        ex_mem_branch_e;
    logic        ex_mem_zero_flag_e;
    logic [31:0] ex_mem_pc_target_e;
    logic [31:0] ex_mem_alu_result_e;
    logic [31:0] ex_mem_writedata_e;
    logic [31:0] ex_mem_pc_plus_4_e;
    logic [4:0]  ex_mem_rd;
    logic [2:0]  ex_mem_funct3_e;
    logic        pc_src;
    logic [31:0] pc_branch_dest;
    logic        writeback_control;
    logic [4:0]  writeback_rd;
    logic [31:0] writeback_data;

    typedef struct {
        string       tag;
        logic        ctrl;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_mem [int];
    int         checks = 0;
    int         failures = 0;

    mem_wb_stage #(.DMEM_WORDS(256), .DMEM_AW(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ex_mem_regwrite_e   (ex_mem_regwrite_e),
        .ex_mem_result_src_e (ex_mem_result_src_e),
        .ex_mem_memwrite_e   (ex_mem_memwrite_e),
        .ex_mem_jump_e       (ex_mem_jump_e),
        .ex_mem_branch_e     (ex_mem_branch_e),
        .ex_mem_zero_flag_e  (ex_mem_zero_flag_e),
        .ex_mem_pc_target_e  (ex_mem_pc_target_e),
        .ex_mem_alu_result_e (ex_mem_alu_result_e),
        .ex_mem_writedata_e  (ex_mem_writedata_e),
        .ex_mem_pc_plus_4_e  (ex_mem_pc_plus_4_e),
        .ex_mem_rd           (ex_mem_rd),
        .ex_mem_funct3_e     (ex_mem_funct3_e),
        .pc_src              (pc_src),
        .pc_branch_dest      (pc_branch_dest),
        .writeback_control   (writeback_control),
        .writeback_rd        (writeback_rd),
        .writeback_data      (writeback_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference memory, 1 KiB wrap.
    task automatic model_store(input logic [31:0] addr, input logic [31:0] d, input logic [2:0] f3);
        int b;
        int w;
        b = int'(addr & 32'h3FF);
        w = b & ~3;
`ifdef DMEM_SUBWORD_EN
        if (f3 == 3'b000) begin
            model_mem[b] = d[7:0];
        end else if (f3 == 3'b001) begin
            model_mem[b & ~1]       = d[7:0];
            model_mem[(b & ~1) + 1] = d[15:8];
        end else begin
            for (int k = 0; k < 4; k++) model_mem[w + k] = d[k*8 +: 8];
        end
`else
        for (int k = 0; k < 4; k++) model_mem[w + k] = d[k*8 +: 8];
`endif
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        int          b;
        int          w;
        int          h;
        logic [31:0] word;
        logic [7:0]  by;
        logic [15:0] hw;
        b    = int'(addr & 32'h3FF);
        w    = b & ~3;
        h    = b & ~1;
        word = {model_mem[w + 3], model_mem[w + 2], model_mem[w + 1], model_mem[w]};
`ifdef DMEM_SUBWORD_EN
        by = model_mem[b];
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) begin
            hw = {model_mem[h + 1], model_mem[h]};
        end else begin
            hw = 16'h0000;
        end
        case (f3)
            3'b000:  return {{24{by[7]}}, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b100:  return {24'h0, by};
            3'b101:  return {16'h0, hw};
            default: return word;
        endcase
`else
        by = 8'h00;
        hw = 16'h0000;
        return word ^ {16'h0000, hw} ^ {24'h0, by};
`endif
    endfunction

    task automatic step(input string tag, input logic rst, input logic rw, input logic [1:0] rs,
                        input logic mw, input logic jmp, input logic br, input logic zf,
                        input logic [31:0] tgt, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc4, input logic [4:0] rd, input logic [2:0] f3);
        exp_t e;
        exp_t got;
        reset               = rst;
        ex_mem_regwrite_e   = rw;
        ex_mem_result_src_e = rs;
        ex_mem_memwrite_e   = mw;
        ex_mem_jump_e       = jmp;
        ex_mem_branch_e     = br;
        ex_mem_zero_flag_e  = zf;
        ex_mem_pc_target_e  = tgt;
        ex_mem_alu_result_e = alu;
        ex_mem_writedata_e  = wd;
        ex_mem_pc_plus_4_e  = pc4;
        ex_mem_rd           = rd;
        ex_mem_funct3_e     = f3;
        #1;
        chk({tag, ".pc_src"}, {31'b0, pc_src}, {31'b0, jmp | (br & zf)});
        chk({tag, ".pc_dest"}, pc_branch_dest, tgt);

        e.tag  = tag;
        e.ctrl = !rst && rw && (rd != 5'd0);
        e.rd   = rst ? 5'd0 : rd;
        if (rst)              e.data = 32'h0;
        else if (rs == 2'b01) e.data = model_load(alu, f3);
        else if (rs == 2'b10) e.data = pc4;
        else                  e.data = alu;
        sb_q.push_back(e);

        @(posedge clk);
        if (mw && !rst) model_store(alu, wd, f3);
        #1;
        got = sb_q.pop_front();
        chk({got.tag, ".wb_ctrl"}, {31'b0, writeback_control}, {31'b0, got.ctrl});
        chk({got.tag, ".wb_rd"}, {27'b0, writeback_rd}, {27'b0, got.rd});
        chk({got.tag, ".wb_data"}, writeback_data, got.data);
        $display("step %-12s pc_src=%0b ctrl=%0b rd=%0d data=%h", tag, pc_src,
                 writeback_control, writeback_rd, writeback_data);
    endtask

    initial begin
        //    tag            rst rw  rs    mw jmp br zf tgt         alu         wd            pc4         rd  f3
        step("pre_store",   0, 0, 2'b00, 1, 0, 0, 0, 32'h0,     32'h30,     32'h00001234, 32'h0,      0, 3'b010);
        step("reset",       1, 1, 2'b00, 1, 0, 0, 0, 32'h0,     32'h30,     32'h00000099, 32'h0,      5, 3'b010);
        step("load_rstmem", 0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h30,     32'h0,        32'h0,      2, 3'b010);
        step("sw_10",       0, 0, 2'b00, 1, 0, 0, 0, 32'h0,     32'h10,     32'hDEADBEEF, 32'h0,      0, 3'b010);
        step("lw_10",       0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h10,     32'h0,        32'h0,      3, 3'b010);
        step("alu_x0",      0, 1, 2'b00, 0, 0, 0, 0, 32'h0,     32'h55,     32'h0,        32'h0,      0, 3'b010);
        step("alu_x7",      0, 1, 2'b00, 0, 0, 0, 0, 32'h0,     32'h55,     32'h0,        32'h0,      7, 3'b010);
        step("br_taken",    0, 0, 2'b00, 0, 0, 1, 1, 32'h40,    32'h0,      32'h0,        32'h0,      0, 3'b010);
        step("br_not",      0, 0, 2'b00, 0, 0, 1, 0, 32'h40,    32'h0,      32'h0,        32'h0,      0, 3'b010);
        step("jal",         0, 1, 2'b10, 0, 1, 0, 0, 32'h80,    32'h1234,   32'h0,        32'h24,     1, 3'b010);
        step("sw_wrap",     0, 0, 2'b00, 1, 0, 0, 0, 32'h0,     32'h400,    32'h11,       32'h0,      0, 3'b010);
        step("lw_wrap",     0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h0,      32'h0,        32'h0,      4, 3'b010);
        step("sw_and_rw",   0, 1, 2'b00, 1, 0, 0, 0, 32'h0,     32'h80,     32'h0000CAFE, 32'h0,      9, 3'b010);
        step("lw_80",       0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h80,     32'h0,        32'h0,      10, 3'b010);
        step("src_11",      0, 1, 2'b11, 0, 0, 0, 1, 32'h0,     32'hA5A5,   32'h0,        32'h77,     31, 3'b010);
`ifdef DMEM_SUBWORD_EN
        step("sw_20",       0, 0, 2'b00, 1, 0, 0, 0, 32'h0,     32'h20,     32'h80FF7F01, 32'h0,      0, 3'b010);
        step("lb_23",       0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h23,     32'h0,        32'h0,      4, 3'b000);
        step("lbu_23",      0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h23,     32'h0,        32'h0,      4, 3'b100);
        step("sb_21",       0, 0, 2'b00, 1, 0, 0, 0, 32'h0,     32'h21,     32'h000000AA, 32'h0,      0, 3'b000);
        step("lw_20",       0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h20,     32'h0,        32'h0,      6, 3'b010);
        step("sh_23",       0, 0, 2'b00, 1, 0, 0, 0, 32'h0,     32'h23,     32'h0000F234, 32'h0,      0, 3'b001);
        step("lh_22",       0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h22,     32'h0,        32'h0,      6, 3'b001);
        step("lhu_22",      0, 1, 2'b01, 0, 0, 0, 0, 32'h0,     32'h22,     32'h0,        32'h0,      6, 3'b101);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
